// File: rtl/shared_pkg.sv
// Shared types for the programmable synchronous FIFO: per-cycle operation encoding.
package shared_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_RW   = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e to_op(input logic wr, input logic rd);
    return fifo_op_e'({rd, wr});
  endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// Wrap-around pointer for arbitrary (non-power-of-2) depth; wraps DEPTH-1 -> 0.
module sync_fifo_ptr #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) begin
      if (ptr_q == PTR_W'(DEPTH - 1)) ptr_d = '0;
      else                            ptr_d = ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/sync_fifo_prog.sv
// Parametrised synchronous FIFO with runtime thresholds, occupancy count and peak watermark.
// Define FIFO_FWFT_EN for first-word-fall-through data_out; otherwise data_out is registered.
module sync_fifo_prog
  import shared_pkg::*;
#(
  parameter  int unsigned FIFO_WIDTH = 16,
  parameter  int unsigned FIFO_DEPTH = 8,
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic [CNT_W-1:0]      af_thresh,
  input  logic [CNT_W-1:0]      ae_thresh,
  input  logic                  clr_peak,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CNT_W-1:0]      count,
  output logic [CNT_W-1:0]      peak
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count_q, count_d, peak_q, peak_d;
  logic                  wr_ack_q, overflow_q, underflow_q;
  logic                  wr_acc, rd_acc;
  fifo_op_e              op;

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);

  // A full FIFO rejects the write even when a read frees a slot in the same cycle.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && !full;
  assign op     = to_op(wr_acc, rd_acc);

  always_comb begin
    count_d = count_q;
    case (op)
      OP_WR:   count_d = count_q + CNT_W'(1);
      OP_RD:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    peak_d = peak_q;
    if (clr_peak)              peak_d = count_d;
    else if (count_d > peak_q) peak_d = count_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      peak_q      <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      peak_q      <= peak_d;
      wr_ack_q    <= wr_acc;
      overflow_q  <= wr_en && !wr_acc;
      underflow_q <= rd_en && !rd_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr] <= data_in;
  end

  sync_fifo_ptr #(.DEPTH(FIFO_DEPTH)) u_wr_ptr (.clk(clk), .rst(rst), .inc(wr_acc), .ptr(wr_ptr));
  sync_fifo_ptr #(.DEPTH(FIFO_DEPTH)) u_rd_ptr (.clk(clk), .rst(rst), .inc(rd_acc), .ptr(rd_ptr));

`ifdef FIFO_FWFT_EN
  assign data_out = empty ? '0 : mem_q[rd_ptr];
`else
  logic [FIFO_WIDTH-1:0] data_out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         data_out_q <= '0;
    else if (rd_acc) data_out_q <= mem_q[rd_ptr];
  end

  assign data_out = data_out_q;
`endif

  assign wr_ack      = wr_ack_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign count       = count_q;
  assign peak        = peak_q;
  assign almostfull  = (count_q >= af_thresh);
  assign almostempty = !empty && (count_q <= ae_thresh);

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed self-checking bench for sync_fifo_prog (depth-8 and depth-5 instances).
module tb_sync_fifo_prog;
  import shared_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          checks = 0;
  int          errors = 0;

  logic        wr8 = 0, rd8 = 0, clr8 = 0;
  logic [15:0] din8 = '0;
  logic [3:0]  af8 = 4'd6, ae8 = 4'd2;
  logic [15:0] dout8;
  logic        ack8, ovf8, udf8, full8, empty8, af_o8, ae_o8;
  logic [3:0]  cnt8, peak8;

  logic        wr5 = 0, rd5 = 0, clr5 = 0;
  logic [15:0] din5 = '0;
  logic [2:0]  af5 = 3'd4, ae5 = 3'd1;
  logic [15:0] dout5;
  logic        ack5, ovf5, udf5, full5, empty5, af_o5, ae_o5;
  logic [2:0]  cnt5, peak5;

  always #5 clk = ~clk;

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .wr_en(wr8), .rd_en(rd8), .data_in(din8),
    .af_thresh(af8), .ae_thresh(ae8), .clr_peak(clr8), .data_out(dout8),
    .wr_ack(ack8), .overflow(ovf8), .underflow(udf8), .full(full8), .empty(empty8),
    .almostfull(af_o8), .almostempty(ae_o8), .count(cnt8), .peak(peak8)
  );

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) u_dut5 (
    .clk(clk), .rst(rst), .wr_en(wr5), .rd_en(rd5), .data_in(din5),
    .af_thresh(af5), .ae_thresh(ae5), .clr_peak(clr5), .data_out(dout5),
    .wr_ack(ack5), .overflow(ovf5), .underflow(udf5), .full(full5), .empty(empty5),
    .almostfull(af_o5), .almostempty(ae_o5), .count(cnt5), .peak(peak5)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] q5[$];
    logic [15:0] exp5;
    int          seq;
    int          ops[8] = '{4, -2, 3, -4, 4, -5, 1, -1};

    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_count", 16'(cnt8), 16'd0);
    chk("rst_empty", 16'(empty8), 16'd1);
    chk("rst_full", 16'(full8), 16'd0);
    chk("rst_af", 16'(af_o8), 16'd0);
    chk("rst_dout", dout8, 16'd0);
    chk("rst_peak", 16'(peak8), 16'd0);
    step();
    rst = 1'b0;

    // Fill 0x0001..0x0008, then overflow
    for (int i = 1; i <= 8; i++) begin
      wr8 = 1'b1; din8 = 16'(i);
      step();
      chk("fill_ack", 16'(ack8), 16'd1);
      chk("fill_count", 16'(cnt8), 16'(i));
      chk("fill_af", 16'(af_o8), 16'(i >= 6));
      chk("fill_ae", 16'(ae_o8), 16'(i <= 2));
    end
    chk("fill_full", 16'(full8), 16'd1);
    din8 = 16'hDEAD;
    step();
    chk("ovf_flag", 16'(ovf8), 16'd1);
    chk("ovf_ack", 16'(ack8), 16'd0);
    chk("ovf_count", 16'(cnt8), 16'd8);
    wr8 = 1'b0;

    // Drain in order, then underflow
    for (int i = 1; i <= 8; i++) begin
      rd8 = 1'b1;
`ifdef FIFO_FWFT_EN
      chk("drain_data", dout8, 16'(i));
      step();
`else
      step();
      chk("drain_data", dout8, 16'(i));
`endif
      chk("drain_count", 16'(cnt8), 16'(8 - i));
    end
    step();
    chk("udf_flag", 16'(udf8), 16'd1);
    chk("udf_empty", 16'(empty8), 16'd1);
    rd8 = 1'b0;

    // Simultaneous wr/rd at full: read wins, write rejected
    for (int i = 1; i <= 8; i++) begin
      wr8 = 1'b1; din8 = 16'(16'h10 + i);
      step();
    end
    rd8 = 1'b1; din8 = 16'hBEEF;
`ifdef FIFO_FWFT_EN
    chk("rw_full_data", dout8, 16'h0011);
    step();
`else
    step();
    chk("rw_full_data", dout8, 16'h0011);
`endif
    chk("rw_full_ovf", 16'(ovf8), 16'd1);
    chk("rw_full_ack", 16'(ack8), 16'd0);
    chk("rw_full_count", 16'(cnt8), 16'd7);
    wr8 = 1'b0;
    for (int i = 2; i <= 8; i++) begin
`ifdef FIFO_FWFT_EN
      chk("rw_drain_data", dout8, 16'(16'h10 + i));
      step();
`else
      step();
      chk("rw_drain_data", dout8, 16'(16'h10 + i));
`endif
    end
    chk("rw_drain_empty", 16'(empty8), 16'd1);

    // Simultaneous wr/rd at empty: write wins, read rejected
    wr8 = 1'b1; din8 = 16'h0055;
    step();
    chk("rw_empty_ack", 16'(ack8), 16'd1);
    chk("rw_empty_udf", 16'(udf8), 16'd1);
    chk("rw_empty_count", 16'(cnt8), 16'd1);
    wr8 = 1'b0; rd8 = 1'b0;

    // Peak watermark then clear
    chk("peak_hold", 16'(peak8), 16'd8);
    clr8 = 1'b1;
    step();
    clr8 = 1'b0;
    chk("peak_clr", 16'(peak8), 16'd1);

    // Mid-burst async reset at count 5
    wr8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din8 = 16'(16'h40 + i);
      step();
    end
    chk("pre_rst_count", 16'(cnt8), 16'd5);
    rst = 1'b1;
    #1;
    chk("mid_rst_count", 16'(cnt8), 16'd0);
    chk("mid_rst_empty", 16'(empty8), 16'd1);
    chk("mid_rst_dout", dout8, 16'd0);
    chk("mid_rst_peak", 16'(peak8), 16'd0);
    wr8 = 1'b0;
    step();
    rst = 1'b0;

`ifdef FIFO_FWFT_EN
    // Fall-through: written word visible without a read
    wr8 = 1'b1; din8 = 16'h00AA;
    step();
    wr8 = 1'b0;
    chk("fwft_data", dout8, 16'h00AA);
    chk("fwft_not_empty", 16'(empty8), 16'd0);
    rd8 = 1'b1;
    step();
    rd8 = 1'b0;
    chk("fwft_pop_empty", 16'(empty8), 16'd1);
`endif

    // Depth 5: pointers wrap twice, order preserved
    seq = 0;
    foreach (ops[k]) begin
      if (ops[k] > 0) begin
        for (int n = 0; n < ops[k]; n++) begin
          wr5 = 1'b1; din5 = 16'(16'h100 + seq);
          q5.push_back(din5);
          seq++;
          step();
          chk("d5_ack", 16'(ack5), 16'd1);
        end
        wr5 = 1'b0;
      end else begin
        for (int n = 0; n < -ops[k]; n++) begin
          rd5 = 1'b1;
          exp5 = q5.pop_front();
`ifdef FIFO_FWFT_EN
          chk("d5_data", dout5, exp5);
          step();
`else
          step();
          chk("d5_data", dout5, exp5);
`endif
        end
        rd5 = 1'b0;
      end
      chk("d5_count", 16'(cnt5), 16'(q5.size()));
      chk("d5_full", 16'(full5), 16'(q5.size() == 5));
      chk("d5_af", 16'(af_o5), 16'(q5.size() >= 4));
      chk("d5_ae", 16'(ae_o5), 16'(q5.size() == 1));
    end
    chk("d5_seq", 16'(seq), 16'd12);
    chk("d5_peak", 16'(peak5), 16'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
